// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// prefetch depth and the fetch FSM state encoding.
package fetch_pkg;

    localparam int AW_DEF    = 16;
    localparam int IW_DEF    = 16;
    localparam int DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO with synchronous clear and simultaneous push/pop.
// The head word is held in a register so downstream sees a clean output;
// it reads as zero whenever the FIFO is empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr, rd_next, wr_next;
    logic [CW-1:0]    count, count_next, remain;
    logic [WIDTH-1:0] head_next;
    logic             pop_en, push_en;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Qualify push/pop and work out the pointers, occupancy and head for next cycle
    always_comb begin
        pop_en     = pop && (count != '0);
        push_en    = push && ((count != CW'(DEPTH)) || pop_en);
        rd_next    = pop_en  ? rd_ptr + PW'(1) : rd_ptr;
        wr_next    = push_en ? wr_ptr + PW'(1) : wr_ptr;
        remain     = count - CW'(pop_en);
        count_next = remain + CW'(push_en);
        head_next  = '0;
        if (count_next == '0) begin
            head_next = '0;
        end else if (remain == '0) begin
            head_next = wdata;
        end else begin
            head_next = store[rd_next];
        end
    end

    // Pointer, occupancy and registered-head state; clear wins over push/pop
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;
            count  <= count_next;
            rdata  <= head_next;
        end
    end

    // Storage array write; contents need no reset because occupancy gates them
    always_ff @(posedge clk) begin
        if (reset && !clear && push_en) begin
            store[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory at the
// current PC, buffers them in a prefetch FIFO and pulses pc_advance for each
// accepted word. A jump (flush) clears the FIFO and discards any in-flight word.
// Optional feature macro: FETCH_ADDR_OUT_EN adds the instr_addr output and
// stores the fetch address alongside each instruction.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int IW    = IW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_addr,
    output logic          pc_advance,
    input  logic          flush,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [IW-1:0] mem_rdata,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
`ifdef FETCH_ADDR_OUT_EN
    output logic [AW-1:0] instr_addr,
`endif
    input  logic          instr_ready
);

`ifdef FETCH_ADDR_OUT_EN
    localparam int FW = AW + IW;
`else
    localparam int FW = IW;
`endif

    fetch_state_t  state, next_state;
    logic          addr_load;
    logic          fifo_push;
    logic          fifo_clear;
    logic          fifo_empty;
    logic          fifo_full;
    logic [FW-1:0] fifo_wdata;
    logic [FW-1:0] fifo_head;

`ifdef FETCH_ADDR_OUT_EN
    assign fifo_wdata            = {mem_addr, mem_rdata};
    assign {instr_addr, instr}   = fifo_head;
`else
    assign fifo_wdata            = mem_rdata;
    assign instr                 = fifo_head;
`endif

    assign instr_valid = !fifo_empty;

    // State register plus the registered memory request and address
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= next_state;
            mem_req  <= (next_state != IDLE);
            if (addr_load) begin
                mem_addr <= pc_addr;
            end
        end
    end

    // Next-state logic, FIFO push/clear and the single-cycle PC advance pulse
    always_comb begin
        next_state = state;
        addr_load  = 1'b0;
        fifo_push  = 1'b0;
        fifo_clear = 1'b0;
        pc_advance = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    fifo_clear = 1'b1;
                end else if (!fifo_full) begin
                    addr_load  = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    fifo_clear = 1'b1;
                    next_state = mem_ack ? IDLE : DROP;
                end else if (mem_ack) begin
                    fifo_push  = 1'b1;
                    pc_advance = 1'b1;
                    next_state = IDLE;
                end
            end
            DROP: begin
                if (flush) begin
                    fifo_clear = 1'b1;
                end
                if (mem_ack) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (fifo_clear),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (instr_ready),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a PC model and a
// variable-latency instruction ROM model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc_addr = 16'h0;
    logic        pc_advance;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
`ifdef FETCH_ADDR_OUT_EN
    logic [15:0] instr_addr;
`endif

    logic [15:0] jump_target = 16'h0;
    int          latency = 0;
    int          wait_cnt = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic        prev_adv = 1'b0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        adv;
        logic        vld;
        logic [15:0] ins;
    } vec_t;

    vec_t vecs [14];

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
`ifdef FETCH_ADDR_OUT_EN
        .instr_addr  (instr_addr),
`endif
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    // ROM answers once the request has been visible for 'latency' cycles
    assign mem_ack   = mem_req && (wait_cnt >= latency);
    assign mem_rdata = rom(mem_addr);

    always @(posedge clk) begin
        if (!reset || !mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // Program counter model: jump has priority over increment
    always @(posedge clk) begin
        if (!reset) pc_addr <= 16'h0;
        else if (flush) pc_addr <= jump_target;
        else if (pc_advance) pc_addr <= pc_addr + 16'h1;
    end

    // pc_advance must never be high on two consecutive cycles
    always @(negedge clk) begin
        if (pc_advance) begin
            compared++;
            if (prev_adv) begin
                mismatched++;
                $display("[TB] FAIL adv_back_to_back: got 1 expected 0 at %0t", $time);
            end
        end
        prev_adv = pc_advance;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset       = v.rst;
        instr_ready = v.rdy;
        step();
    endtask

    task automatic doReset();
        reset = 1'b0;
        flush = 1'b0;
        step();
        checkOutput("rst_req_drop", mem_req, 0);
        step();
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_adv", pc_advance, 0);
        checkOutput("rst_valid", instr_valid, 0);
        checkOutput("rst_instr", instr, 0);
        reset = 1'b1;
    endtask

    // Accept n words with ready held high and compare each against the ROM
    task automatic drainCheck(input int n, input logic [15:0] first, input int budget);
        logic [15:0] exp_a;
        int          got;
        int          cyc;
        exp_a = first;
        got = 0;
        cyc = 0;
        instr_ready = 1'b1;
        while (got < n && cyc < budget) begin
            if (instr_valid) begin
                checkOutput($sformatf("drain_instr_%h", exp_a), instr, rom(exp_a));
`ifdef FETCH_ADDR_OUT_EN
                checkOutput($sformatf("drain_addr_%h", exp_a), instr_addr, exp_a);
`endif
                exp_a = exp_a + 16'h1;
                got++;
            end
            step();
            cyc++;
        end
        if (got < n) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d words expected %0d", got, n);
        end
    endtask

    initial begin
        // rst rdy | req addr adv vld instr
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h0, 1'b1, 1'b0, 16'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, rom(16'h0)};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h1, 1'b1, 1'b0, 16'h0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h1, 1'b0, 1'b1, rom(16'h1)};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'h2, 1'b1, 1'b0, 16'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h2, 1'b0, 1'b1, rom(16'h2)};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 16'h3, 1'b1, 1'b0, 16'h0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h3, 1'b0, 1'b1, rom(16'h3)};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h4, 1'b1, 1'b0, 16'h0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 16'h4, 1'b0, 1'b1, rom(16'h4)};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h5, 1'b1, 1'b0, 16'h0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h5, 1'b0, 1'b1, rom(16'h5)};

        $display("[TB] reset and zero-latency stream");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_req", i), mem_req, vecs[i].req);
            checkOutput($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            checkOutput($sformatf("vec%0d_adv", i), pc_advance, vecs[i].adv);
            checkOutput($sformatf("vec%0d_valid", i), instr_valid, vecs[i].vld);
            checkOutput($sformatf("vec%0d_instr", i), instr, vecs[i].ins);
        end

        $display("[TB] backpressure");
        instr_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("full_no_req", mem_req, 0);
            checkOutput("full_head", instr, rom(16'h5));
            checkOutput("full_valid", instr_valid, 1);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checkOutput("pop_one_head", instr, rom(16'h6));
        checkOutput("pop_one_valid", instr_valid, 1);
        checkOutput("pop_one_no_req", mem_req, 0);
        step();
        drainCheck(6, 16'h6, 60);

        $display("[TB] jump during slow request");
        latency = 3;
        doReset();
        step();
        checkOutput("slow_req", mem_req, 1);
        checkOutput("slow_addr", mem_addr, 0);
        flush       = 1'b1;
        jump_target = 16'h0040;
        step();
        flush = 1'b0;
        checkOutput("drop_req_held", mem_req, 1);
        checkOutput("drop_addr_held", mem_addr, 0);
        checkOutput("drop_valid", instr_valid, 0);
        checkOutput("drop_pc", pc_addr, 16'h0040);
        step();
        step();
        checkOutput("drop_ack_no_adv", pc_advance, 0);
        step();
        checkOutput("drop_done_req", mem_req, 0);
        checkOutput("drop_done_valid", instr_valid, 0);
        checkOutput("drop_done_pc", pc_addr, 16'h0040);
        step();
        checkOutput("redirect_req", mem_req, 1);
        checkOutput("redirect_addr", mem_addr, 16'h0040);
        drainCheck(1, 16'h0040, 20);

        $display("[TB] jump with full FIFO");
        latency     = 0;
        instr_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checkOutput("fill_valid", instr_valid, 1);
        checkOutput("fill_no_req", mem_req, 0);
        checkOutput("fill_head", instr, rom(16'h0041));
        flush       = 1'b1;
        jump_target = 16'h0100;
        step();
        flush = 1'b0;
        checkOutput("flush_valid", instr_valid, 0);
        checkOutput("flush_instr", instr, 0);
        checkOutput("flush_no_req", mem_req, 0);
        checkOutput("flush_pc", pc_addr, 16'h0100);
        drainCheck(3, 16'h0100, 40);

        $display("[TB] reset mid-request and address wrap");
        latency = 5;
        begin
            int cyc;
            cyc = 0;
            while (!mem_req && cyc < 20) begin
                step();
                cyc++;
            end
            checkOutput("midreq_seen", mem_req, 1);
        end
        latency = 0;
        doReset();
        step();
        checkOutput("wrap_first_req", mem_req, 1);
        flush       = 1'b1;
        jump_target = 16'hFFFE;
        #1;
        checkOutput("flush_ack_no_adv", pc_advance, 0);
        step();
        flush = 1'b0;
        checkOutput("flush_ack_valid", instr_valid, 0);
        checkOutput("flush_ack_pc", pc_addr, 16'hFFFE);
        drainCheck(4, 16'hFFFE, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
